// File: rtl/sha.sv
// Shared types, round counts and round constants for the SHA-1 / SHA-256 round engine.
package sha;

  typedef enum logic {
    MODE_SHA1   = 1'b0,
    MODE_SHA256 = 1'b1
  } mode_t;

  typedef logic [255:0] mainloop_word_t;

  localparam logic [6:0] ROUNDS_SHA1   = 7'd80;
  localparam logic [6:0] ROUNDS_SHA256 = 7'd64;

  localparam logic [31:0] K1_0 = 32'h5a827999;
  localparam logic [31:0] K1_1 = 32'h6ed9eba1;
  localparam logic [31:0] K1_2 = 32'h8f1bbcdc;
  localparam logic [31:0] K1_3 = 32'hca62c1d6;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (~x & z);
  endfunction

  function automatic logic [31:0] f_maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic [31:0] f_parity(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

endpackage

// File: rtl/sha_round.sv
// One SHA-1 or SHA-256 compression round, purely combinational.
// SHA-1 drives state words f..h to zero so they never leak into the result.
module sha_round
  import sha::*;
(
  input  mode_t          i_mode,
  input  logic [6:0]     i_round,
  input  logic [31:0]    i_w,
  input  mainloop_word_t i_state,
  output mainloop_word_t o_state
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_f1, w_k1, w_t1_sha1;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

  always_comb begin
    w_f1 = f_parity(w_b, w_c, w_d);
    w_k1 = K1_3;
    if (i_round < 7'd20) begin
      w_f1 = f_ch(w_b, w_c, w_d);
      w_k1 = K1_0;
    end else if (i_round < 7'd40) begin
      w_k1 = K1_1;
    end else if (i_round < 7'd60) begin
      w_f1 = f_maj(w_b, w_c, w_d);
      w_k1 = K1_2;
    end
  end

  assign w_t1_sha1 = rotl(w_a, 5) + w_f1 + w_e + w_k1 + i_w;

  assign w_t1 = w_h + (rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25))
              + f_ch(w_e, w_f, w_g) + K256[i_round[5:0]] + i_w;
  assign w_t2 = (rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22)) + f_maj(w_a, w_b, w_c);

  assign o_state = (i_mode == MODE_SHA1)
                 ? {w_t1_sha1, w_a, rotl(w_b, 30), w_c, w_d, 96'd0}
                 : {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha_round_engine.sv
// SHA-1/SHA-256 round engine: UNROLL chained rounds per accepted W beat, done one cycle after the last beat.
// Stalls hold all state; SHA_ROUND_FEEDFWD_EN adds iv into ripe to form the chaining value.
module sha_round_engine
  import sha::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  mode_t                mode,
  input  mainloop_word_t       iv,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [UNROLL*32-1:0] w_data,
  output logic                 busy,
  output logic                 done,
  output mainloop_word_t       ripe,
  output logic [6:0]           round
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha_round_engine: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  mode_t          r_mode;
  logic [6:0]     r_round;
  mainloop_word_t r_work;
  mainloop_word_t r_ripe;

  logic           w_xfer;
  logic [6:0]     w_round_nxt;
  logic [6:0]     w_last;
  mainloop_word_t w_ripe_nxt;
  mainloop_word_t w_chain [UNROLL+1];

  assign w_ready     = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign ripe        = r_ripe;
  assign round       = r_round;
  assign w_xfer      = w_valid && w_ready;
  assign w_round_nxt = r_round + 7'(UNROLL);
  assign w_last      = (r_mode == MODE_SHA1) ? ROUNDS_SHA1 : ROUNDS_SHA256;

  assign w_chain[0] = r_work;
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    sha_round u_round (
      .i_mode (r_mode),
      .i_round(r_round + 7'(gi)),
      .i_w    (w_data[32*gi +: 32]),
      .i_state(w_chain[gi]),
      .o_state(w_chain[gi+1])
    );
  end

`ifdef SHA_ROUND_FEEDFWD_EN
  mainloop_word_t r_iv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_iv <= '0;
    end else if (start && (r_state != S_RUN)) begin
      r_iv <= iv;
    end
  end

  always_comb begin
    w_ripe_nxt = '0;
    for (int j = 0; j < 8; j++) begin
      w_ripe_nxt[32*j +: 32] = r_iv[32*j +: 32] + w_chain[UNROLL][32*j +: 32];
    end
    if (r_mode == MODE_SHA1) begin
      w_ripe_nxt[95:0] = '0;
    end
  end
`else
  always_comb begin
    w_ripe_nxt = w_chain[UNROLL];
    if (r_mode == MODE_SHA1) begin
      w_ripe_nxt[95:0] = '0;
    end
  end
`endif

  // ripe is captured on the final transfer so it is valid for the whole DONE cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_SHA1;
      r_round <= '0;
      r_work  <= '0;
      r_ripe  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            r_round <= '0;
            r_work  <= iv;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_work  <= w_chain[UNROLL];
            r_round <= w_round_nxt;
            if (w_round_nxt == w_last) begin
              r_state <= S_DONE;
              r_ripe  <= w_ripe_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_engine.sv
// Scoreboard bench: two engines (UNROLL=1 and UNROLL=4) fed padded "abc" schedules against known digests.
module tb_sha_round_engine;
  import sha::*;

  logic clk;
  logic rstn;
  logic start1, start4;
  mode_t mode;
  mainloop_word_t iv;
  logic wv1, wr1, busy1, done1;
  logic [31:0] wd1;
  mainloop_word_t ripe1;
  logic [6:0] round1;
  logic wv4, wr4, busy4, done4;
  logic [127:0] wd4;
  mainloop_word_t ripe4;
  logic [6:0] round4;

  typedef struct {
    logic [255:0] dig;
    int           at;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] ws1 [80];
  logic [31:0] ws256 [80];
  logic [255:0] exp256, exp1;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DIG256 = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                     32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  // words 5..7 of the SHA-1 IV carry junk that must never reach ripe
  localparam logic [255:0] IV1 = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
                                  32'hc3d2e1f0, 32'hdeadbeef, 32'h01234567, 32'h89abcdef};
  localparam logic [255:0] DIG1 = {32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c,
                                   32'h9cd0d89d, 32'h00000000, 32'h00000000, 32'h00000000};

  sha_round_engine #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .mode(mode), .iv(iv),
    .w_valid(wv1), .w_ready(wr1), .w_data(wd1),
    .busy(busy1), .done(done1), .ripe(ripe1), .round(round1)
  );

  sha_round_engine #(.UNROLL(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .mode(mode), .iv(iv),
    .w_valid(wv4), .w_ready(wr4), .w_data(wd4),
    .busy(busy4), .done(done4), .ripe(ripe4), .round(round4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sub_iv(input logic [255:0] d, input logic [255:0] v, input int nw);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < nw; i++) r[255-32*i -: 32] = d[255-32*i -: 32] - v[255-32*i -: 32];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      chk("done1_expected", 256'(q1.size() != 0), 256'(1));
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("digest1", ripe1, e.dig);
        if (e.at >= 0) chk("done1_cycle", 256'(cyc), 256'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      chk("done4_expected", 256'(q4.size() != 0), 256'(1));
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("digest4", ripe4, e.dig);
        if (e.at >= 0) chk("done4_cycle", 256'(cyc), 256'(e.at));
      end
    end
  end

  task automatic do_start(input int sel, input mode_t m, input logic [255:0] v,
                          input bit want_done, input logic [255:0] dig, input int lat);
    exp_t e;
    mode = m;
    iv = v;
    e.dig = dig;
    e.at = (lat < 0) ? -1 : cyc + lat;
    if (want_done) begin
      if (sel == 1) q1.push_back(e);
      else q4.push_back(e);
    end
    if (sel == 1) start1 = 1'b1;
    else start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic feed(input int sel, input mode_t m, input int pct, input int mid_start, input int stop_beat);
    int u, nb, k, guard;
    logic [255:0] d;
    logic vld, hs;
    logic [6:0] rnd;
    u = (sel == 1) ? 1 : 4;
    nb = ((m == MODE_SHA1) ? 80 : 64) / u;
    if (stop_beat < nb) nb = stop_beat;
    k = 0;
    guard = 0;
    while (k < nb && guard < 400) begin
      vld = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      d = '0;
      for (int j = 0; j < u; j++) d[32*j +: 32] = (m == MODE_SHA1) ? ws1[k*u+j] : ws256[k*u+j];
      if (sel == 1) begin wv1 = vld; wd1 = d[31:0]; end
      else begin wv4 = vld; wd4 = d[127:0]; end
      if (k == mid_start) begin
        if (sel == 1) start1 = 1'b1;
        else start4 = 1'b1;
      end
      @(negedge clk);
      hs = vld && ((sel == 1) ? wr1 : wr4);
      rnd = (sel == 1) ? round1 : round4;
      chk("round_index", 256'(rnd), 256'(k * u));
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start4 = 1'b0;
      if (hs) k++;
      guard++;
    end
    chk("beats_accepted", 256'(k), 256'(nb));
    wv1 = 1'b0;
    wv4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        ws1[t] = (t == 0) ? 32'h61626380 : (t == 15) ? 32'h00000018 : 32'h0;
        ws256[t] = ws1[t];
      end else begin
        ws1[t] = rr(ws1[t-3] ^ ws1[t-8] ^ ws1[t-14] ^ ws1[t-16], 31);
        if (t < 64)
          ws256[t] = (rr(ws256[t-2], 17) ^ rr(ws256[t-2], 19) ^ (ws256[t-2] >> 10)) + ws256[t-7]
                   + (rr(ws256[t-15], 7) ^ rr(ws256[t-15], 18) ^ (ws256[t-15] >> 3)) + ws256[t-16];
        else
          ws256[t] = 32'h0;
      end
    end
`ifdef SHA_ROUND_FEEDFWD_EN
    exp256 = DIG256;
    exp1   = DIG1;
`else
    exp256 = sub_iv(DIG256, IV256, 8);
    exp1   = sub_iv(DIG1, IV1, 5);
`endif

    rstn = 1'b0; start1 = 1'b0; start4 = 1'b0;
    wv1 = 1'b0; wv4 = 1'b0; wd1 = '0; wd4 = '0;
    mode = MODE_SHA256; iv = '0;
    #2;
    chk("rst_busy", 256'(busy1), 256'(0));
    chk("rst_done", 256'(done1), 256'(0));
    chk("rst_w_ready", 256'(wr1), 256'(0));
    chk("rst_round", 256'(round1), 256'(0));
    chk("rst_ripe", ripe1, 256'(0));
    chk("rst_w_ready4", 256'(wr4), 256'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // start on the first edge after reset release
    do_start(1, MODE_SHA256, IV256, 1'b1, exp256, 65);
    feed(1, MODE_SHA256, 100, -1, 99);
    idle(3);

    do_start(4, MODE_SHA1, IV1, 1'b1, exp1, 21);
    feed(4, MODE_SHA1, 100, -1, 99);
    idle(3);

    do_start(4, MODE_SHA256, IV256, 1'b1, exp256, 17);
    feed(4, MODE_SHA256, 100, -1, 99);
    idle(3);

    do_start(1, MODE_SHA1, IV1, 1'b1, exp1, 81);
    feed(1, MODE_SHA1, 100, -1, 99);
    idle(3);

    do_start(1, MODE_SHA256, IV256, 1'b1, exp256, -1);
    feed(1, MODE_SHA256, 50, -1, 99);
    idle(3);

    // abort at round 30: outputs clear without a clock edge, no done follows
    do_start(1, MODE_SHA256, IV256, 1'b0, exp256, -1);
    feed(1, MODE_SHA256, 100, -1, 30);
    rstn = 1'b0;
    #1;
    chk("abort_busy", 256'(busy1), 256'(0));
    chk("abort_done", 256'(done1), 256'(0));
    chk("abort_w_ready", 256'(wr1), 256'(0));
    chk("abort_round", 256'(round1), 256'(0));
    chk("abort_ripe", ripe1, 256'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    do_start(1, MODE_SHA256, IV256, 1'b1, exp256, 65);
    feed(1, MODE_SHA256, 100, -1, 99);
    idle(3);

    // start pulse mid-RUN is ignored; start during DONE chains straight into RUN
    do_start(1, MODE_SHA256, IV256, 1'b1, exp256, 65);
    feed(1, MODE_SHA256, 100, 10, 99);
    do_start(1, MODE_SHA256, IV256, 1'b1, exp256, 65);
    chk("rerun_busy", 256'(busy1), 256'(1));
    chk("rerun_round", 256'(round1), 256'(0));
    feed(1, MODE_SHA256, 100, -1, 99);
    idle(5);

    chk("pending_q1", 256'(q1.size()), 256'(0));
    chk("pending_q4", 256'(q4.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
